// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the IF and MEM pipeline stages.
// Accesses are serialised one at a time, and IF is guaranteed a grant after a bounded run of MEM grants.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RAM_LAT      = 2,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_done_o,
    output logic              stall_if_o,
    output logic              stall_mem_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] MaxRun  = CNT_W'(MAX_DATA_RUN);
    localparam logic [CNT_W-1:0] LatLoad = CNT_W'(RAM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state_q, state_d;

    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  runCnt_q, runCnt_d;
    logic [CNT_W-1:0]  latCnt_q, latCnt_d;
    logic              ramEn_q, ramEn_d;
    logic              ramWe_q, ramWe_d;
    logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
    logic [DATA_W-1:0] ramWdata_q, ramWdata_d;
    logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
    logic [DATA_W-1:0] memRdata_q, memRdata_d;
    logic              ifDone_q, ifDone_d;
    logic              memDone_q, memDone_d;

    logic anyReq;
    logic runAtMax;
    logic grantIf;

    // MEM (older instruction) wins ties unless IF has waited out a full run of MEM grants.
    assign anyReq   = if_req_i | mem_req_i;
    assign runAtMax = (runCnt_q == MaxRun);
    assign grantIf  = if_req_i & (~mem_req_i | runAtMax);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (anyReq) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (latCnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d      = sel_q;
        we_d       = we_q;
        runCnt_d   = runCnt_q;
        latCnt_d   = latCnt_q;
        ramEn_d    = 1'b0;
        ramWe_d    = 1'b0;
        ramAddr_d  = ramAddr_q;
        ramWdata_d = ramWdata_q;
        ifRdata_d  = ifRdata_q;
        memRdata_d = memRdata_q;
        ifDone_d   = 1'b0;
        memDone_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    ramEn_d = 1'b1;
                    if (grantIf) begin
                        sel_d     = 1'b0;
                        we_d      = 1'b0;
                        ramAddr_d = if_addr_i;
                        runCnt_d  = '0;
                    end else begin
                        sel_d      = 1'b1;
                        we_d       = mem_we_i;
                        ramWe_d    = mem_we_i;
                        ramAddr_d  = mem_addr_i;
                        ramWdata_d = mem_wdata_i;
                        if (!if_req_i) begin
                            runCnt_d = '0;
                        end else if (!runAtMax) begin
                            runCnt_d = runCnt_q + 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                latCnt_d = LatLoad;
            end
            WAIT: begin
                // Capture edge: ram_rdata is valid exactly now; writes only pulse done.
                if (latCnt_q == '0) begin
                    if (sel_q) begin
                        memDone_d = 1'b1;
                        if (!we_q) memRdata_d = ram_rdata_i;
                    end else begin
                        ifDone_d  = 1'b1;
                        ifRdata_d = ram_rdata_i;
                    end
                end else begin
                    latCnt_d = latCnt_q - 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            runCnt_q   <= '0;
            latCnt_q   <= '0;
            ramEn_q    <= 1'b0;
            ramWe_q    <= 1'b0;
            ramAddr_q  <= '0;
            ramWdata_q <= '0;
            ifRdata_q  <= '0;
            memRdata_q <= '0;
            ifDone_q   <= 1'b0;
            memDone_q  <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            we_q       <= we_d;
            runCnt_q   <= runCnt_d;
            latCnt_q   <= latCnt_d;
            ramEn_q    <= ramEn_d;
            ramWe_q    <= ramWe_d;
            ramAddr_q  <= ramAddr_d;
            ramWdata_q <= ramWdata_d;
            ifRdata_q  <= ifRdata_d;
            memRdata_q <= memRdata_d;
            ifDone_q   <= ifDone_d;
            memDone_q  <= memDone_d;
        end
    end

    assign if_rdata_o  = ifRdata_q;
    assign if_done_o   = ifDone_q;
    assign mem_rdata_o = memRdata_q;
    assign mem_done_o  = memDone_q;
    assign ram_en_o    = ramEn_q;
    assign ram_we_o    = ramWe_q;
    assign ram_addr_o  = ramAddr_q;
    assign ram_wdata_o = ramWdata_q;
    assign stall_if_o  = if_req_i & ~ifDone_q;
    assign stall_mem_o = mem_req_i & ~memDone_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing cases, a latency sweep and randomized
// traffic checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
    localparam int LAT    = 2;
    localparam int MAXRUN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset;
    logic        ifReq, memReq, memWe;
    logic [31:0] ifAddr, memAddr, memWdata;
    logic [31:0] ifRdata, memRdata, ramAddr, ramWdata, ramRdata;
    logic        ifDone, memDone, stallIf, stallMem, ramEn, ramWe;

    logic        ifReqA, ifReqB, memOff;
    logic [31:0] ifAddrA, ifAddrB, zeroWord;
    logic [31:0] ifRdataA, memRdataA, ramAddrA, ramWdataA, ramRdataA;
    logic [31:0] ifRdataB, memRdataB, ramAddrB, ramWdataB, ramRdataB;
    logic        ifDoneA, memDoneA, stallIfA, stallMemA, ramEnA, ramWeA;
    logic        ifDoneB, memDoneB, stallIfB, stallMemB, ramEnB, ramWeB;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT), .MAX_DATA_RUN(MAXRUN)) dut (
        .clk_i(clk), .reset_i(reset),
        .if_req_i(ifReq), .if_addr_i(ifAddr), .if_rdata_o(ifRdata), .if_done_o(ifDone),
        .mem_req_i(memReq), .mem_we_i(memWe), .mem_addr_i(memAddr), .mem_wdata_i(memWdata),
        .mem_rdata_o(memRdata), .mem_done_o(memDone),
        .stall_if_o(stallIf), .stall_mem_o(stallMem),
        .ram_en_o(ramEn), .ram_we_o(ramWe), .ram_addr_o(ramAddr), .ram_wdata_o(ramWdata),
        .ram_rdata_i(ramRdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1), .MAX_DATA_RUN(MAXRUN)) dutLat1 (
        .clk_i(clk), .reset_i(reset),
        .if_req_i(ifReqA), .if_addr_i(ifAddrA), .if_rdata_o(ifRdataA), .if_done_o(ifDoneA),
        .mem_req_i(memOff), .mem_we_i(memOff), .mem_addr_i(zeroWord), .mem_wdata_i(zeroWord),
        .mem_rdata_o(memRdataA), .mem_done_o(memDoneA),
        .stall_if_o(stallIfA), .stall_mem_o(stallMemA),
        .ram_en_o(ramEnA), .ram_we_o(ramWeA), .ram_addr_o(ramAddrA), .ram_wdata_o(ramWdataA),
        .ram_rdata_i(ramRdataA)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(4), .MAX_DATA_RUN(MAXRUN)) dutLat4 (
        .clk_i(clk), .reset_i(reset),
        .if_req_i(ifReqB), .if_addr_i(ifAddrB), .if_rdata_o(ifRdataB), .if_done_o(ifDoneB),
        .mem_req_i(memOff), .mem_we_i(memOff), .mem_addr_i(zeroWord), .mem_wdata_i(zeroWord),
        .mem_rdata_o(memRdataB), .mem_done_o(memDoneB),
        .stall_if_o(stallIfB), .stall_mem_o(stallMemB),
        .ram_en_o(ramEnB), .ram_we_o(ramWeB), .ram_addr_o(ramAddrB), .ram_wdata_o(ramWdataB),
        .ram_rdata_i(ramRdataB)
    );

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] defaultWord(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // RAM model: data for a read appears exactly LAT cycles after its ram_en cycle, garbage otherwise.
    logic [31:0] ramMem [logic [31:0]];
    logic [31:0] rdHold = '0;
    int          rdCyc = -100;

    function automatic logic [31:0] ramRead(input logic [31:0] a);
        if (ramMem.exists(a)) return ramMem[a];
        return defaultWord(a);
    endfunction

    always @(posedge clk) begin
        if (ramEn) begin
            if (ramWe) ramMem[ramAddr] = ramWdata;
            else begin
                rdHold <= ramRead(ramAddr);
                rdCyc  <= cyc;
            end
        end
    end
    assign ramRdata = (cyc == rdCyc + LAT) ? rdHold : 32'hBADD_0000;

    int enCycA = -100;
    int enCycB = -100;
    always @(posedge clk) begin
        if (ramEnA) enCycA <= cyc;
        if (ramEnB) enCycB <= cyc;
    end
    assign ramRdataA = (cyc == enCycA + 1) ? (ramAddrA ^ 32'h1111_0000) : 32'hBADD_0001;
    assign ramRdataB = (cyc == enCycB + 4) ? (ramAddrB ^ 32'h1111_0000) : 32'hBADD_0004;

    // Transaction-level reference: one access at a time, fixed occupancy, winner rule with run count.
    logic [31:0] modelMem [logic [31:0]];
    int          freeCyc, expCyc, runCnt;
    bit          expActive, expMem, expWe, ifDoneSeen, memDoneSeen;
    logic [31:0] expAddr, expWdata, expData, modelIfData, modelMemData;
    bit          doneLog[$];

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        if (modelMem.exists(a)) return modelMem[a];
        return defaultWord(a);
    endfunction

    task automatic modelStep();
        bit doneNow, issueNow, ifDoneExp, memDoneExp;
        doneNow    = expActive && (cyc == expCyc);
        issueNow   = expActive && (cyc == expCyc - LAT - 1);
        ifDoneExp  = doneNow && !expMem;
        memDoneExp = doneNow && expMem;
        if (ifDoneExp) modelIfData = expData;
        if (memDoneExp && !expWe) modelMemData = expData;
        checkOutput("ifDone", 32'(ifDone), 32'(ifDoneExp));
        checkOutput("memDone", 32'(memDone), 32'(memDoneExp));
        checkOutput("ramEn", 32'(ramEn), 32'(issueNow));
        checkOutput("ramWe", 32'(ramWe), 32'(issueNow && expWe));
        if (issueNow) checkOutput("ramAddr", ramAddr, expAddr);
        if (issueNow && expWe) checkOutput("ramWdata", ramWdata, expWdata);
        checkOutput("ifRdata", ifRdata, modelIfData);
        checkOutput("memRdata", memRdata, modelMemData);
        checkOutput("stallIf", 32'(stallIf), 32'(ifReq && !ifDoneExp));
        checkOutput("stallMem", 32'(stallMem), 32'(memReq && !memDoneExp));
        ifDoneSeen  = ifDoneExp;
        memDoneSeen = memDoneExp;
        if (doneNow) begin
            expActive = 1'b0;
            doneLog.push_back(expMem);
        end
        if (cyc >= freeCyc && (ifReq || memReq)) begin
            expActive = 1'b1;
            expCyc    = cyc + LAT + 2;
            freeCyc   = cyc + LAT + 3;
            if (ifReq && (!memReq || runCnt == MAXRUN)) begin
                expMem  = 1'b0;
                expWe   = 1'b0;
                expAddr = ifAddr;
                expData = modelRead(ifAddr);
                runCnt  = 0;
            end else begin
                expMem   = 1'b1;
                expWe    = memWe;
                expAddr  = memAddr;
                expWdata = memWdata;
                if (memWe) modelMem[memAddr] = memWdata;
                else expData = modelRead(memAddr);
                runCnt = ifReq ? ((runCnt < MAXRUN) ? runCnt + 1 : MAXRUN) : 0;
            end
        end
    endtask

    task automatic applyStimulus(input int ifPct, input int memPct, input int wePct);
        if (ifReq && ifDoneSeen) ifReq = 1'b0;
        if (memReq && memDoneSeen) memReq = 1'b0;
        if (!ifReq && $urandom_range(99) < ifPct) begin
            ifReq  = 1'b1;
            ifAddr = ($urandom_range(1) == 0 ? 32'h0040_0000 : 32'h1001_0000) + (32'($urandom_range(7)) << 2);
        end
        if (!memReq && $urandom_range(99) < memPct) begin
            memReq   = 1'b1;
            memWe    = ($urandom_range(99) < wePct);
            memAddr  = 32'h1001_0000 + (32'($urandom_range(7)) << 2);
            memWdata = $urandom;
        end
    endtask

    task automatic runTraffic(input int n, input int ifPct, input int memPct, input int wePct);
        for (int i = 0; i < n; i++) begin
            applyStimulus(ifPct, memPct, wePct);
            @(negedge clk);
            modelStep();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        reset  = 1'b1;
        ifReq  = 1'b1;
        memReq = 1'b0;
        memWe  = 1'b0;
        ifReqA = 1'b0;
        ifReqB = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstIfRdata", ifRdata, '0);
        checkOutput("rstMemRdata", memRdata, '0);
        checkOutput("rstDones", {30'd0, ifDone, memDone}, '0);
        checkOutput("rstRamCtl", {30'd0, ramEn, ramWe}, '0);
        checkOutput("rstRamAddr", ramAddr, '0);
        checkOutput("rstRamWdata", ramWdata, '0);
        checkOutput("rstStallIf", 32'(stallIf), 32'd1);
        checkOutput("rstStallMem", 32'(stallMem), 32'd0);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        ifReq        = 1'b0;
        freeCyc      = 0;
        runCnt       = 0;
        expActive    = 1'b0;
        ifDoneSeen   = 1'b0;
        memDoneSeen  = 1'b0;
        modelIfData  = '0;
        modelMemData = '0;
        modelMem     = ramMem;
        doneLog.delete();
    endtask

    logic [15:0] ifDoneV, memDoneV, ramEnV, ramWeV, stallIfV, stallMemV;
    logic [15:0] doneAV, enAV, doneBV, enBV;
    logic [31:0] firstIfRdata;

    task automatic recordCycles(input int n);
        {ifDoneV, memDoneV, ramEnV, ramWeV, stallIfV, stallMemV} = '0;
        {doneAV, enAV, doneBV, enBV} = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) firstIfRdata = ifRdata;
            ifDoneV[i] = ifDone;   memDoneV[i] = memDone;
            ramEnV[i]  = ramEn;    ramWeV[i]   = ramWe;
            stallIfV[i] = stallIf; stallMemV[i] = stallMem;
            doneAV[i] = ifDoneA;   enAV[i] = ramEnA;
            doneBV[i] = ifDoneB;   enBV[i] = ramEnB;
            @(posedge clk);
            #1;
            if (ifDoneV[i]) ifReq = 1'b0;
            if (memDoneV[i]) memReq = 1'b0;
        end
    endtask

    logic [9:0] seq;

    initial begin
        memOff   = 1'b0;
        zeroWord = '0;
        ifAddr   = '0;
        memAddr  = '0;
        memWdata = '0;
        ifAddrA  = 32'h0040_0010;
        ifAddrB  = 32'h0040_0020;
        ramMem[32'h0040_0000] = 32'h2008_0005;
        doReset();

        ifReq  = 1'b1;
        ifAddr = 32'h0040_0000;
        recordCycles(8);
        checkOutput("t1IfDoneCycle", 32'(ifDoneV), 32'h0010);
        checkOutput("t1RamEnCycle", 32'(ramEnV), 32'h0002);
        checkOutput("t1StallIf", 32'(stallIfV), 32'h000F);
        checkOutput("t1IfRdata", ifRdata, 32'h2008_0005);

        memReq   = 1'b1;
        memWe    = 1'b1;
        memAddr  = 32'h1001_0000;
        memWdata = 32'hDEAD_BEEF;
        recordCycles(8);
        memWe = 1'b0;
        checkOutput("t2RamWeCycle", 32'(ramWeV), 32'h0002);
        checkOutput("t2MemDoneCycle", 32'(memDoneV), 32'h0010);
        checkOutput("t2MemRdataHeld", memRdata, 32'h0);
        checkOutput("t2RamContents", ramRead(32'h1001_0000), 32'hDEAD_BEEF);

        ifReq   = 1'b1;
        ifAddr  = 32'h0040_0004;
        memReq  = 1'b1;
        memAddr = 32'h1001_0000;
        recordCycles(12);
        checkOutput("t3MemDoneCycle", 32'(memDoneV), 32'h0010);
        checkOutput("t3IfDoneCycle", 32'(ifDoneV), 32'h0200);
        checkOutput("t3RamEnCycles", 32'(ramEnV), 32'h0042);
        checkOutput("t3StallMem", 32'(stallMemV), 32'h000F);
        checkOutput("t3MemRdata", memRdata, 32'hDEAD_BEEF);
        checkOutput("t3IfRdata", ifRdata, defaultWord(32'h0040_0004));

        ifReq  = 1'b1;
        ifAddr = 32'h0040_0000;
        repeat (2) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5StallInReset", 32'(stallIf), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ifReq = 1'b0;
        recordCycles(6);
        checkOutput("t5NoIfDone", 32'(ifDoneV), 32'h0);
        checkOutput("t5NoRamEn", 32'(ramEnV), 32'h0);
        checkOutput("t5IfRdataCleared", firstIfRdata, 32'h0);
        checkOutput("t5MemRdataCleared", memRdata, 32'h0);

        ifReqA = 1'b1;
        ifReqB = 1'b1;
        recordCycles(16);
        checkOutput("lat1DoneCycles", 32'(doneAV), 32'h8888);
        checkOutput("lat1RamEnCycles", 32'(enAV), 32'h2222);
        checkOutput("lat4DoneCycles", 32'(doneBV), 32'h2040);
        checkOutput("lat4RamEnCycles", 32'(enBV), 32'h8102);
        checkOutput("lat1IfRdata", ifRdataA, 32'h0040_0010 ^ 32'h1111_0000);
        checkOutput("lat4IfRdata", ifRdataB, 32'h0040_0020 ^ 32'h1111_0000);
        @(negedge clk);
        checkOutput("latStallIf", {30'd0, stallIfA, stallIfB}, 32'd3);
        checkOutput("latMemSide", {28'd0, memDoneA, memDoneB, stallMemA, stallMemB}, 32'd0);
        checkOutput("latRamWe", {30'd0, ramWeA, ramWeB}, 32'd0);
        checkOutput("latMemRdata", memRdataA | memRdataB, 32'd0);
        checkOutput("latRamWdata", ramWdataA | ramWdataB, 32'd0);
        @(posedge clk);
        #1;

        doReset();
        runTraffic(60, 100, 100, 0);
        checkOutput("starveCount", 32'(doneLog.size() >= 10), 32'd1);
        seq = '0;
        for (int k = 0; k < 10 && k < doneLog.size(); k++) seq[k] = doneLog[k];
        checkOutput("starveOrder", 32'(seq), 32'(10'b01111_01111));

        doReset();
        runTraffic(800, 35, 45, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
